// File: rtl/branch_seq.sv
// branch_seq: branch PC sequencer with a two-cycle comparator round trip and a sequential fast path
module branch_seq #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  br_op_in,
  input  logic [31:0] imm_off,
  output logic [2:0]  br_op,
  input  logic        is_branch,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        busy,
  output logic [15:0] taken_count
);
  typedef enum logic [1:0] {IDLE, EVAL, WAIT} state_t;
  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] imm_q;
  logic        slow;
  assign slow        = br_op_in != 3'd0 && br_op_in <= 3'd4;
  assign instr_ready = state == IDLE;
  assign busy        = state != IDLE;
  assign br_op       = state == EVAL ? op_q : 3'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      pc_valid    <= 1'b0;
      flush       <= 1'b0;
      taken_count <= 16'd0;
      op_q        <= 3'd0;
      imm_q       <= 32'd0;
    end else begin
      pc_valid <= 1'b0;
      flush    <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          if (slow) begin
            op_q  <= br_op_in;
            imm_q <= imm_off;
            state <= EVAL;
          end else begin
            pc       <= pc + PC_STEP;
            pc_valid <= 1'b1;
          end
        end
        EVAL: state <= WAIT;
        WAIT: begin
          pc       <= pc + (is_branch ? imm_q : PC_STEP);
          pc_valid <= 1'b1;
          flush    <= is_branch;
          if (is_branch && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed checks of branch_seq against hand-computed pc/flag/counter values
module tb_branch_seq;
  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready, is_branch, pc_valid, flush, busy;
  logic [2:0]  br_op_in, br_op;
  logic [31:0] imm_off, pc;
  logic [15:0] taken_count;
  int          n_run = 0, n_fail = 0;
  logic [31:0] exp_pc;
  logic [15:0] exp_cnt;
  branch_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_op_in(br_op_in), .imm_off(imm_off), .br_op(br_op), .is_branch(is_branch),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .busy(busy), .taken_count(taken_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'd0;
    exp_cnt = 16'd0;
  endtask
  task automatic fast(input logic [2:0] op);
    instr_valid = 1'b1;
    br_op_in = op;
    @(negedge clk);
    instr_valid = 1'b0;
    exp_pc = exp_pc + 32'd4;
    chk("fast_pc", pc, exp_pc);
    chk("fast_pv", {31'd0, pc_valid}, 1);
    chk("fast_flush", {31'd0, flush}, 0);
  endtask
  task automatic branch(input logic [2:0] op, input logic [31:0] imm, input logic tk);
    instr_valid = 1'b1;
    br_op_in = op;
    imm_off = imm;
    is_branch = tk;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("eval_brop", {29'd0, br_op}, {29'd0, op});
    chk("eval_busy", {31'd0, busy}, 1);
    chk("eval_ready", {31'd0, instr_ready}, 0);
    chk("eval_pc", pc, exp_pc);
    @(negedge clk);
    chk("wait_brop", {29'd0, br_op}, 0);
    chk("wait_busy", {31'd0, busy}, 1);
    chk("wait_pv", {31'd0, pc_valid}, 0);
    @(negedge clk);
    exp_pc = exp_pc + (tk ? imm : 32'd4);
    if (tk && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    chk("upd_pc", pc, exp_pc);
    chk("upd_pv", {31'd0, pc_valid}, 1);
    chk("upd_flush", {31'd0, flush}, {31'd0, tk});
    chk("upd_cnt", {16'd0, taken_count}, {16'd0, exp_cnt});
    chk("upd_ready", {31'd0, instr_ready}, 1);
    @(negedge clk);
    chk("post_pv", {31'd0, pc_valid}, 0);
    chk("post_flush", {31'd0, flush}, 0);
  endtask
  initial begin
    rst = 1'b1; instr_valid = 1'b0; br_op_in = 3'd0; imm_off = 32'd0; is_branch = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_pv", {31'd0, pc_valid}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_cnt", {16'd0, taken_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, instr_ready}, 1);
    chk("rst_brop", {29'd0, br_op}, 0);
    branch(3'b001, 32'h40, 1'b1);
    chk("taken_pc40", pc, 32'h40);
    do_reset();
    branch(3'b100, 32'h100, 1'b0);
    chk("nt_pc4", pc, 32'h4);
    do_reset();
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      br_op_in = (i == 0) ? 3'b000 : (i == 1) ? 3'b101 : 3'b111;
      @(negedge clk);
      exp_pc = exp_pc + 32'd4;
      chk("b2b_pc", pc, exp_pc);
      chk("b2b_pv", {31'd0, pc_valid}, 1);
      chk("b2b_brop", {29'd0, br_op}, 0);
      chk("b2b_busy", {31'd0, busy}, 0);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_pc", pc, 32'hC);
    chk("b2b_end_pv", {31'd0, pc_valid}, 0);
    do_reset();
    fast(3'b000);
    fast(3'b110);
    branch(3'b010, 32'hFFFF_FFF0, 1'b1);
    chk("wrap_down", pc, 32'hFFFF_FFF8);
    fast(3'b000);
    fast(3'b000);
    chk("wrap_up", pc, 32'h0);
    fast(3'b101);
    instr_valid = 1'b1; br_op_in = 3'b011; imm_off = 32'h20; is_branch = 1'b1;
    @(negedge clk);
    br_op_in = 3'b000;
    chk("ign_eval_brop", {29'd0, br_op}, 3'b011);
    chk("ign_eval_pc", pc, exp_pc);
    @(negedge clk);
    chk("ign_wait_pc", pc, exp_pc);
    chk("ign_wait_pv", {31'd0, pc_valid}, 0);
    chk("ign_wait_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; instr_valid = 1'b0;
    exp_pc = 32'd0; exp_cnt = 16'd0;
    chk("wrst_pc", pc, 32'd0);
    chk("wrst_pv", {31'd0, pc_valid}, 0);
    chk("wrst_flush", {31'd0, flush}, 0);
    chk("wrst_ready", {31'd0, instr_ready}, 1);
    chk("wrst_busy", {31'd0, busy}, 0);
    chk("wrst_cnt", {16'd0, taken_count}, 0);
    @(negedge clk);
    chk("wrst_pv2", {31'd0, pc_valid}, 0);
    chk("wrst_pc2", pc, 32'd0);
    branch(3'b001, 32'h8, 1'b1);
    branch(3'b011, 32'h8, 1'b1);
    chk("cnt2", {16'd0, taken_count}, 32'd2);
    force dut.taken_count = 16'hFFFD;
    @(negedge clk);
    release dut.taken_count;
    exp_cnt = 16'hFFFD;
    @(negedge clk);
    chk("sat_pre", {16'd0, taken_count}, 32'hFFFD);
    branch(3'b001, 32'h4, 1'b1);
    branch(3'b010, 32'h4, 1'b1);
    branch(3'b011, 32'h4, 1'b1);
    branch(3'b100, 32'h4, 1'b1);
    chk("sat_hold", {16'd0, taken_count}, 32'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, is the value loaded into pc on reset.
REQ-002 Parameter PC_STEP, default 32'd4, is the sequential PC increment.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset.
REQ-005 instr_valid  input  1  indicates a branch instruction is offered.
REQ-006 instr_ready  output  1  is high when the block accepts an instruction (IDLE only).
REQ-007 br_op_in  input  3  is the branch opcode of the offered instruction.
REQ-008 imm_off  input  32  is the signed byte offset of the offered instruction.
REQ-009 br_op  output  3  is the opcode driven to the registered branch comparator.
REQ-010 is_branch  input  1  is the comparator result, valid the cycle after br_op is driven.
REQ-011 pc  output  32  is the current program counter (registered).
REQ-012 pc_valid  output  1  is a one-cycle pulse in the cycle after pc changes.
REQ-013 flush  output  1  is a one-cycle pulse, coincident with pc_valid, when the branch was taken.
REQ-014 busy  output  1  is high in EVAL and WAIT.
REQ-015 taken_count  output  16  counts taken branches since reset.

Function
REQ-016 The block SHALL implement FSM states IDLE, EVAL and WAIT, with instr_ready = (state==IDLE).
REQ-017 Handshake: an instruction is accepted on a clock edge where instr_valid && instr_ready; while instr_ready is low, instr_valid SHALL be ignored.
REQ-018 On accept with br_op_in in {001,010,011,100}, the block SHALL latch br_op_in and imm_off and go IDLE->EVAL.
REQ-019 On accept with br_op_in in {000,101,110,111} (fast path), the block SHALL set pc <= pc+PC_STEP on that edge, pulse pc_valid the next cycle with flush=0, and stay in IDLE.
REQ-020 In EVAL, br_op SHALL equal the latched opcode; in every other state br_op SHALL be 3'b000; EVAL->WAIT is unconditional.
REQ-021 In WAIT, the block SHALL sample is_branch and, on the edge leaving WAIT, set pc <= pc+imm_off if taken, else pc <= pc+PC_STEP, then go WAIT->IDLE.
REQ-022 pc_valid SHALL pulse for exactly one cycle after every pc update, and flush SHALL equal the taken decision in that cycle; both SHALL be 0 otherwise.
REQ-023 Latency: accept edge k -> pc updated at edge k+2 -> pc_valid/flush high in cycle k+2..k+3; the next instruction can be accepted at edge k+3.
REQ-024 PC arithmetic SHALL be 32-bit modulo 2^32 (imm_off two's complement), wrapping silently in both directions.
REQ-025 taken_count SHALL increment by 1 on each taken branch and saturate at 16'hFFFF.
REQ-026 A back-to-back fast-path accept SHALL be allowed on every cycle, so pc_valid may be high on consecutive cycles.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL set state=IDLE, pc=PC_RESET, pc_valid=0, flush=0, taken_count=0, and clear the latched opcode/offset; it SHALL drive br_op=000 and busy=0.
REQ-028 rst SHALL take priority over all other inputs, including an accept or a WAIT-state update on the same edge; any in-flight instruction is discarded without updating pc.

Verification
REQ-029 Reset, then accept op=001, imm_off=32'h40 -> br_op=001 for one cycle, pc=32'h40 two edges after accept, pc_valid=flush=1 for one cycle, taken_count=1.
REQ-030 Accept op=100, the comparator returns is_branch=0, imm_off=32'h100 -> pc=PC_RESET+4, pc_valid=1, flush=0, taken_count unchanged.
REQ-031 Accept op=000 on 3 consecutive cycles -> pc increments by 4 each cycle, pc_valid high on 3 consecutive cycles, br_op stays 000, busy stays 0.
REQ-032 With pc=32'h0000_0008, take a branch with imm_off=32'hFFFF_FFF0 -> pc=32'hFFFF_FFF8 (wrap); with pc=32'hFFFF_FFFC, fast path -> pc=32'h0.
REQ-033 Assert rst during WAIT with is_branch=1 -> pc=PC_RESET, no pc_valid/flush pulse, state IDLE, and instr_valid asserted during EVAL/WAIT produces no accept.
REQ-034 Force 65537 taken branches -> taken_count holds at 16'hFFFF.
